fifo_main: RTL and testbench

- Main ingress FIFO for the QoS path.
- Buffers 6-bit words from the packet source and presents the head word in first-word-fall-through (FWFT) form to the main pop-conditioning stage.
- That stage reads Main_data_out in the same cycle it asserts Main_rd, and gates Main_rd only on VC almost-full and Main_empty.
- Provides full/empty, programmable almost-full/almost-empty flags, occupancy count and a sticky error flag.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_flags.sv | 36 +++
 rtl/fifo_main.sv | 127 ++++++++++++
 tb/tb_fifo_main.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the QoS-path FIFOs (main ingress and VC0/VC1 FIFOs).
//   MAIN_DATA_W : word width of the main ingress FIFO
//   MAIN_DEPTH  : number of entries (power of two, >= 4)
//   MAIN_ADDR_W : log2(MAIN_DEPTH), pointer width
//   MAIN_VC_BIT : bit of a word that carries the VC id, used by the
//                 downstream demux stages
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int MAIN_DATA_W = 6;
  localparam int MAIN_DEPTH  = 8;
  localparam int MAIN_ADDR_W = 3;
  localparam int MAIN_VC_BIT = MAIN_DATA_W - 1;

endpackage : fifo_pkg

// File: rtl/fifo_flags.sv
// ---------------------------------------------------------------------------
// fifo_flags
// Pure combinational decode of a FIFO occupancy count into status flags.
// Shared by the main ingress FIFO and the VC0/VC1 FIFOs.
// Ports:
//   count        in  ADDR_W+1  registered occupancy
//   thr_af       in  ADDR_W+1  almost-full threshold (legal 1..DEPTH)
//   thr_ae       in  ADDR_W+1  almost-empty threshold (legal 0..DEPTH-1)
//   empty        out 1         count == 0
//   full         out 1         count == DEPTH
//   almost_full  out 1         count >= thr_af
//   almost_empty out 1         count <= thr_ae
// ---------------------------------------------------------------------------
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int DEPTH  = MAIN_DEPTH,
  parameter int ADDR_W = MAIN_ADDR_W
) (
  input  logic [ADDR_W:0] count,
  input  logic [ADDR_W:0] thr_af,
  input  logic [ADDR_W:0] thr_ae,
  output logic            empty,
  output logic            full,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= thr_af);
  assign almost_empty = (count <= thr_ae);

endmodule : fifo_flags

// File: rtl/fifo_main.sv
// ---------------------------------------------------------------------------
// fifo_main
// Main ingress FIFO for the QoS path. Buffers words from the packet source
// and presents the head word first-word-fall-through: the pop stage reads
// Main_data_out in the same cycle it asserts Main_rd.
//
// Optional build macro: MAIN_FIFO_STATS_EN adds saturating 8-bit counters
// of dropped writes (Main_ovf_cnt) and ignored reads (Main_udf_cnt).
//
// Ports:
//   clk                  in  1         sole clock, rising edge
//   reset                in  1         synchronous, active-high
//   Main_wr              in  1         push request
//   Main_data_in         in  DATA_W    push data
//   Main_rd              in  1         pop request, head consumed at the edge
//   Umbral_almost_full   in  ADDR_W+1  almost-full threshold
//   Umbral_almost_empty  in  ADDR_W+1  almost-empty threshold
//   Main_data_out        out DATA_W    head word, 0 when empty
//   Main_empty           out 1         count == 0
//   Main_full            out 1         count == DEPTH
//   Main_almost_full     out 1         count >= Umbral_almost_full
//   Main_almost_empty    out 1         count <= Umbral_almost_empty
//   Main_count           out ADDR_W+1  occupancy
//   Main_ovf_cnt         out 8         (stats build only) dropped writes
//   Main_udf_cnt         out 8         (stats build only) ignored reads
//   Main_error           out 1         sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module fifo_main
  import fifo_pkg::*;
#(
  parameter int DATA_W = MAIN_DATA_W,
  parameter int DEPTH  = MAIN_DEPTH,
  parameter int ADDR_W = MAIN_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Main_wr,
  input  logic [DATA_W-1:0] Main_data_in,
  input  logic              Main_rd,
  input  logic [ADDR_W:0]   Umbral_almost_full,
  input  logic [ADDR_W:0]   Umbral_almost_empty,
  output logic [DATA_W-1:0] Main_data_out,
  output logic              Main_empty,
  output logic              Main_full,
  output logic              Main_almost_full,
  output logic              Main_almost_empty,
  output logic [ADDR_W:0]   Main_count,
`ifdef MAIN_FIFO_STATS_EN
  output logic [7:0]        Main_ovf_cnt,
  output logic [7:0]        Main_udf_cnt,
`endif
  output logic              Main_error
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic push;
  logic pop;
  logic overflow;
  logic underflow;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push      = Main_wr && (!Main_full || Main_rd);
  assign pop       = Main_rd && !Main_empty;
  assign overflow  = Main_wr && Main_full && !Main_rd;
  assign underflow = Main_rd && Main_empty;

  fifo_flags #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_flags (
    .count        (count),
    .thr_af       (Umbral_almost_full),
    .thr_ae       (Umbral_almost_empty),
    .empty        (Main_empty),
    .full         (Main_full),
    .almost_full  (Main_almost_full),
    .almost_empty (Main_almost_empty)
  );

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are valid, and leaving the array unreset lets it map onto plain
  // flops or a register file without a reset tree.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Main_data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      Main_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (overflow || underflow) Main_error <= 1'b1;
    end
  end

`ifdef MAIN_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Main_ovf_cnt <= '0;
      Main_udf_cnt <= '0;
    end else begin
      if (overflow && (Main_ovf_cnt != 8'hFF))  Main_ovf_cnt <= Main_ovf_cnt + 8'd1;
      if (underflow && (Main_udf_cnt != 8'hFF)) Main_udf_cnt <= Main_udf_cnt + 8'd1;
    end
  end
`endif

  // Fall-through read straight from the array; forced to zero when empty so
  // stale entries never leak downstream.
  assign Main_data_out = Main_empty ? '0 : mem[rd_ptr];
  assign Main_count    = count;

endmodule : fifo_main

// File: tb/tb_fifo_main.sv
// ---------------------------------------------------------------------------
// tb_fifo_main
// Self-checking bench for fifo_main: a table of per-cycle input/expected
// records followed by hand-written sequences for reset and underflow cases.
// Thresholds: almost-full = 6, almost-empty = 1 throughout.
// ---------------------------------------------------------------------------
module tb_fifo_main;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [5:0] din;
    logic [3:0] cnt;
    logic [5:0] dout;
    logic       empty;
    logic       full;
    logic       af;
    logic       ae;
    logic       err;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       Main_wr;
  logic [5:0] Main_data_in;
  logic       Main_rd;
  logic [3:0] Umbral_almost_full;
  logic [3:0] Umbral_almost_empty;
  logic [5:0] Main_data_out;
  logic       Main_empty;
  logic       Main_full;
  logic       Main_almost_full;
  logic       Main_almost_empty;
  logic [3:0] Main_count;
  logic       Main_error;
`ifdef MAIN_FIFO_STATS_EN
  logic [7:0] Main_ovf_cnt;
  logic [7:0] Main_udf_cnt;
`endif

  int tests_run;
  int tests_failed;
  vec_t vecs[$];

  fifo_main dut (
    .clk                 (clk),
    .reset               (reset),
    .Main_wr             (Main_wr),
    .Main_data_in        (Main_data_in),
    .Main_rd             (Main_rd),
    .Umbral_almost_full  (Umbral_almost_full),
    .Umbral_almost_empty (Umbral_almost_empty),
    .Main_data_out       (Main_data_out),
    .Main_empty          (Main_empty),
    .Main_full           (Main_full),
    .Main_almost_full    (Main_almost_full),
    .Main_almost_empty   (Main_almost_empty),
    .Main_count          (Main_count),
`ifdef MAIN_FIFO_STATS_EN
    .Main_ovf_cnt        (Main_ovf_cnt),
    .Main_udf_cnt        (Main_udf_cnt),
`endif
    .Main_error          (Main_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare every output against one set of expected values.
  task automatic check_all(input string tag, input logic [3:0] cnt, input logic [5:0] dout,
                           input logic empty, input logic full, input logic af,
                           input logic ae, input logic err);
    check({tag, " count"}, 32'(Main_count), 32'(cnt));
    check({tag, " dout"}, 32'(Main_data_out), 32'(dout));
    check({tag, " flags{e,f,af,ae}"},
          32'({Main_empty, Main_full, Main_almost_full, Main_almost_empty}),
          32'({empty, full, af, ae}));
    check({tag, " error"}, 32'(Main_error), 32'(err));
  endtask

  // Drive one cycle of inputs, let the edge pass, sample 1 time unit later.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [5:0] din);
    reset        = rst;
    Main_wr      = wr;
    Main_rd      = rd;
    Main_data_in = din;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic wr, input logic rd,
                              input logic [5:0] din, input logic [3:0] cnt,
                              input logic [5:0] dout, input logic empty, input logic full,
                              input logic af, input logic ae, input logic err);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
    v.cnt = cnt; v.dout = dout; v.empty = empty; v.full = full;
    v.af = af; v.ae = ae; v.err = err;
    return v;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //                rst wr rd din    cnt dout   e  f  af ae err
    // Three writes, then three FWFT reads.
    vecs.push_back(mk(0, 1, 0, 6'h21, 1, 6'h21, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 6'h05, 2, 6'h21, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h3F, 3, 6'h21, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 2, 6'h05, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 1, 6'h3F, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 0, 6'h00, 1, 0, 0, 1, 0));
    // Fill to 8: almost-empty clears at 2, almost-full rises at 6, full at 8.
    vecs.push_back(mk(0, 1, 0, 6'h01, 1, 6'h01, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 6'h02, 2, 6'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h03, 3, 6'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h04, 4, 6'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h05, 5, 6'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h06, 6, 6'h01, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h07, 7, 6'h01, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h08, 8, 6'h01, 0, 1, 1, 0, 0));
    // Full with simultaneous write+read for 10 cycles: count holds, no error,
    // order preserved across the pointer wrap.
    vecs.push_back(mk(0, 1, 1, 6'h10, 8, 6'h02, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h11, 8, 6'h03, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h12, 8, 6'h04, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h13, 8, 6'h05, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h14, 8, 6'h06, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h15, 8, 6'h07, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h16, 8, 6'h08, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h17, 8, 6'h10, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h18, 8, 6'h11, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h19, 8, 6'h12, 0, 1, 1, 0, 0));
    // Write alone into a full FIFO: dropped, error set.
    vecs.push_back(mk(0, 1, 0, 6'h2A, 8, 6'h12, 0, 1, 1, 0, 1));
    // Drain: 0x12..0x19 remain, the dropped 0x2A must never appear.
    vecs.push_back(mk(0, 0, 1, 6'h00, 7, 6'h13, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 6, 6'h14, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 5, 6'h15, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 4, 6'h16, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 6'h17, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 2, 6'h18, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 1, 6'h19, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 0, 6'h00, 1, 0, 0, 1, 1));

    Umbral_almost_full  = 4'd6;
    Umbral_almost_empty = 4'd1;

    // Reset state.
    step(1, 0, 0, 6'h00);
    check_all("reset", 0, 6'h00, 1, 0, 0, 1, 0);
`ifdef MAIN_FIFO_STATS_EN
    check("reset ovf_cnt", 32'(Main_ovf_cnt), 0);
    check("reset udf_cnt", 32'(Main_udf_cnt), 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_all($sformatf("v%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].empty,
                vecs[i].full, vecs[i].af, vecs[i].ae, vecs[i].err);
    end
`ifdef MAIN_FIFO_STATS_EN
    check("table ovf_cnt", 32'(Main_ovf_cnt), 1);
    check("table udf_cnt", 32'(Main_udf_cnt), 0);
`endif

    // Empty + read + write: read ignored with error, write still lands.
    step(1, 0, 0, 6'h00);
    check("clr error", 32'(Main_error), 0);
    step(0, 1, 1, 6'h12);
    check_all("empty wr+rd", 1, 6'h12, 0, 0, 0, 1, 1);
`ifdef MAIN_FIFO_STATS_EN
    check("empty wr+rd udf_cnt", 32'(Main_udf_cnt), 1);
`endif

    // Build up to count 5, then reset with a concurrent write: reset wins.
    for (int k = 0; k < 4; k++) step(0, 1, 0, 6'(6'h30 + k));
    check("pre-reset count", 32'(Main_count), 5);
    step(1, 1, 0, 6'h3C);
    check_all("mid reset", 0, 6'h00, 1, 0, 0, 1, 0);
`ifdef MAIN_FIFO_STATS_EN
    check("mid reset ovf_cnt", 32'(Main_ovf_cnt), 0);
    check("mid reset udf_cnt", 32'(Main_udf_cnt), 0);
`endif

    // Read alone on empty: error set, nothing else moves.
    step(0, 0, 1, 6'h00);
    check_all("empty rd", 0, 6'h00, 1, 0, 0, 1, 1);
    // Error is sticky with idle inputs.
    step(0, 0, 0, 6'h00);
    check("error sticky", 32'(Main_error), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fifo_main
